// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared datapath types for the CPU core.
//   word_t   : 32-bit architectural data word
//   regidx_t : architectural register index (default 32 registers -> 5 bits)
//   REG_ZERO : index of the hardwired zero register
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] regidx_t;

  localparam regidx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Per-register pending (busy) bits for the register file. Issue marks a
// destination pending, writeback clears it, flush clears everything.
// Priority (highest first): RST, FLUSH, issue set, writeback clear.
// Bit 0 is never set.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   ISS, isel       issue strobe and destination index
//   WEN0, wsel0     write port 0 enable / index (clears busy)
//   WEN1, wsel1     write port 1 enable / index (clears busy)
//   FLUSH           clear all pending bits
//   busy            registered busy vector, one bit per register
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ISS,
  input  logic [AW-1:0]    isel,
  input  logic             WEN0,
  input  logic [AW-1:0]    wsel0,
  input  logic             WEN1,
  input  logic [AW-1:0]    wsel1,
  input  logic             FLUSH,
  output logic [NREGS-1:0] busy
);
  import cpu_types_pkg::*;

  localparam logic [AW-1:0] ZIDX = AW'(REG_ZERO);

  logic [NREGS-1:0] busy_nxt;

  // Later assignments override earlier ones, giving clear < set < flush.
  always_comb begin
    busy_nxt = busy;
    if (WEN0 && (wsel0 != ZIDX)) busy_nxt[wsel0] = 1'b0;
    if (WEN1 && (wsel1 != ZIDX)) busy_nxt[wsel1] = 1'b0;
    if (ISS  && (isel  != ZIDX)) busy_nxt[isel]  = 1'b1;
    if (FLUSH)                   busy_nxt        = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
// Scoreboarded multi-port register file: NRD combinational read ports, two
// write ports (port 1 wins on a same-index collision), and a per-register
// busy bit kept by regfile_scoreboard. Register 0 reads as zero, never busy.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read of a register being written this cycle returns the
//               incoming data (port 1 preferred) and reports not-busy.
//   undefined : reads return stored contents and stored busy bits only.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   rsel  [NRD][AW]       read selects
//   rdat  [NRD][WIDTH]    read data
//   rbusy [NRD]           busy flag of the selected register
//   WEN0, wsel0, wdat0    write port 0 (older instruction)
//   WEN1, wsel1, wdat1    write port 1 (younger instruction, priority)
//   ISS, isel             issue: mark isel pending
//   FLUSH                 clear all pending bits
// ---------------------------------------------------------------------------
module register_file_sb #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NRD-1:0][AW-1:0]    rsel,
  output logic [NRD-1:0][WIDTH-1:0] rdat,
  output logic [NRD-1:0]            rbusy,
  input  logic                      WEN0,
  input  logic [AW-1:0]             wsel0,
  input  logic [WIDTH-1:0]          wdat0,
  input  logic                      WEN1,
  input  logic [AW-1:0]             wsel1,
  input  logic [WIDTH-1:0]          wdat1,
  input  logic                      ISS,
  input  logic [AW-1:0]             isel,
  input  logic                      FLUSH
);
  import cpu_types_pkg::*;

  localparam logic [AW-1:0] ZIDX = AW'(REG_ZERO);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr0;
  logic             wr1;

  assign wr0 = WEN0 && (wsel0 != ZIDX);
  assign wr1 = WEN1 && (wsel1 != ZIDX);

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .CLK   (CLK),
    .RST   (RST),
    .ISS   (ISS),
    .isel  (isel),
    .WEN0  (WEN0),
    .wsel0 (wsel0),
    .WEN1  (WEN1),
    .wsel1 (wsel1),
    .FLUSH (FLUSH),
    .busy  (busy)
  );

  // Port 1 is assigned last so its data lands on a same-index collision.
  // Index 0 is never written, so regs[0] keeps its reset value of zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      if (wr0) regs[wsel0] <= wdat0;
      if (wr1) regs[wsel1] <= wdat1;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdat[i]  = regs[rsel[i]];
      rbusy[i] = busy[rsel[i]];
`ifdef REGFILE_BYPASS_EN
      // The in-flight write resolves the hazard, so the port is not busy
      // even if the same index is being re-issued this cycle.
      if (wr1 && (wsel1 == rsel[i])) begin
        rdat[i]  = wdat1;
        rbusy[i] = 1'b0;
      end else if (wr0 && (wsel0 == rsel[i])) begin
        rdat[i]  = wdat0;
        rbusy[i] = 1'b0;
      end
`endif
      // Forced zero also masks the unreset contents of regs[0] at power-up.
      if (rsel[i] == ZIDX) begin
        rdat[i]  = '0;
        rbusy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// ---------------------------------------------------------------------------
// tb_register_file_sb
// Two instances: default geometry (32x32, 2 read ports) and a reduced one
// (16-bit, 8 registers, 4 read ports). Directed scenarios plus randomized
// traffic compared against a behavioural model held in plain arrays.
// ---------------------------------------------------------------------------
module tb_register_file_sb;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Instance A: WIDTH=32, NREGS=32, NRD=2
  logic [1:0][4:0]  a_rsel;
  logic [1:0][31:0] a_rdat;
  logic [1:0]       a_rbusy;
  logic             a_wen0, a_wen1, a_iss, a_flush;
  logic [4:0]       a_wsel0, a_wsel1, a_isel;
  logic [31:0]      a_wdat0, a_wdat1;

  // Instance B: WIDTH=16, NREGS=8, NRD=4
  logic [3:0][2:0]  b_rsel;
  logic [3:0][15:0] b_rdat;
  logic [3:0]       b_rbusy;
  logic             b_wen0, b_wen1, b_iss, b_flush;
  logic [2:0]       b_wsel0, b_wsel1, b_isel;
  logic [15:0]      b_wdat0, b_wdat1;

  register_file_sb dut_a (
    .CLK(clk), .RST(rst), .rsel(a_rsel), .rdat(a_rdat), .rbusy(a_rbusy),
    .WEN0(a_wen0), .wsel0(a_wsel0), .wdat0(a_wdat0),
    .WEN1(a_wen1), .wsel1(a_wsel1), .wdat1(a_wdat1),
    .ISS(a_iss), .isel(a_isel), .FLUSH(a_flush)
  );

  register_file_sb #(.WIDTH(16), .NREGS(8), .NRD(4)) dut_b (
    .CLK(clk), .RST(rst), .rsel(b_rsel), .rdat(b_rdat), .rbusy(b_rbusy),
    .WEN0(b_wen0), .wsel0(b_wsel0), .wdat0(b_wdat0),
    .WEN1(b_wen1), .wsel1(b_wsel1), .wdat1(b_wdat1),
    .ISS(b_iss), .isel(b_isel), .FLUSH(b_flush)
  );

  // Reference state: architectural contents and pending flags.
  logic [31:0] ma_regs [32];
  logic        ma_busy [32];
  logic [15:0] mb_regs [8];
  logic        mb_busy [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_a();
    rst = 1'b0; a_wen0 = 1'b0; a_wen1 = 1'b0; a_iss = 1'b0; a_flush = 1'b0;
    a_wsel0 = '0; a_wsel1 = '0; a_isel = '0; a_wdat0 = '0; a_wdat1 = '0;
  endtask

  task automatic idle_b();
    b_wen0 = 1'b0; b_wen1 = 1'b0; b_iss = 1'b0; b_flush = 1'b0;
    b_wsel0 = '0; b_wsel1 = '0; b_isel = '0; b_wdat0 = '0; b_wdat1 = '0;
  endtask

  // Called at a negedge with inputs applied: check reads, clock, update model.
  task automatic step_a();
    #1;
    for (int i = 0; i < 2; i++) begin
      int          s;
      logic [31:0] ed;
      logic        eb;
      s  = int'(a_rsel[i]);
      ed = ma_regs[s];
      eb = ma_busy[s];
`ifdef REGFILE_BYPASS_EN
      if (a_wen0 && int'(a_wsel0) == s) begin ed = a_wdat0; eb = 1'b0; end
      if (a_wen1 && int'(a_wsel1) == s) begin ed = a_wdat1; eb = 1'b0; end
`endif
      if (s == 0) begin ed = '0; eb = 1'b0; end
      chk($sformatf("a_rdat%0d_r%0d", i, s), a_rdat[i], ed);
      chk($sformatf("a_rbusy%0d_r%0d", i, s), {31'b0, a_rbusy[i]}, {31'b0, eb});
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin ma_regs[r] = '0; ma_busy[r] = 1'b0; end
    end else begin
      if (a_wen0 && a_wsel0 != 0) ma_regs[a_wsel0] = a_wdat0;
      if (a_wen1 && a_wsel1 != 0) ma_regs[a_wsel1] = a_wdat1;
      if (a_flush) begin
        for (int r = 0; r < 32; r++) ma_busy[r] = 1'b0;
      end else begin
        if (a_wen0 && a_wsel0 != 0) ma_busy[a_wsel0] = 1'b0;
        if (a_wen1 && a_wsel1 != 0) ma_busy[a_wsel1] = 1'b0;
        if (a_iss  && a_isel  != 0) ma_busy[a_isel]  = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic step_b();
    #1;
    for (int i = 0; i < 4; i++) begin
      int          s;
      logic [15:0] ed;
      logic        eb;
      s  = int'(b_rsel[i]);
      ed = mb_regs[s];
      eb = mb_busy[s];
`ifdef REGFILE_BYPASS_EN
      if (b_wen0 && int'(b_wsel0) == s) begin ed = b_wdat0; eb = 1'b0; end
      if (b_wen1 && int'(b_wsel1) == s) begin ed = b_wdat1; eb = 1'b0; end
`endif
      if (s == 0) begin ed = '0; eb = 1'b0; end
      chk($sformatf("b_rdat%0d_r%0d", i, s), {16'b0, b_rdat[i]}, {16'b0, ed});
      chk($sformatf("b_rbusy%0d_r%0d", i, s), {31'b0, b_rbusy[i]}, {31'b0, eb});
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 8; r++) begin mb_regs[r] = '0; mb_busy[r] = 1'b0; end
    end else begin
      if (b_wen0 && b_wsel0 != 0) mb_regs[b_wsel0] = b_wdat0;
      if (b_wen1 && b_wsel1 != 0) mb_regs[b_wsel1] = b_wdat1;
      if (b_flush) begin
        for (int r = 0; r < 8; r++) mb_busy[r] = 1'b0;
      end else begin
        if (b_wen0 && b_wsel0 != 0) mb_busy[b_wsel0] = 1'b0;
        if (b_wen1 && b_wsel1 != 0) mb_busy[b_wsel1] = 1'b0;
        if (b_iss  && b_isel  != 0) mb_busy[b_isel]  = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Directed read with constant expectations (no clock advance).
  task automatic peek_a(input int p, input logic [4:0] r, input string tag,
                        input logic [31:0] ed, input logic eb);
    a_rsel[p] = r;
    #1;
    chk({tag, "_dat"}, a_rdat[p], ed);
    chk({tag, "_busy"}, {31'b0, a_rbusy[p]}, {31'b0, eb});
  endtask

  function automatic logic [4:0] pick_a();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_a(); idle_b();
    a_rsel = '0; b_rsel = '0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin ma_regs[r] = '0; ma_busy[r] = 1'b0; end
    for (int r = 0; r < 8; r++)  begin mb_regs[r] = '0; mb_busy[r] = 1'b0; end

    // Reset state
    a_rsel[0] = 5'd5; a_rsel[1] = 5'd31;
    step_a();

    // Reset discards written data and pending bits
    a_wen0 = 1'b1; a_wsel0 = 5'd5; a_wdat0 = 32'hDEADBEEF;
    a_iss = 1'b1; a_isel = 5'd5;
    step_a(); idle_a();
    peek_a(0, 5'd5, "pre_rst_r5", 32'hDEADBEEF, 1'b1);
    step_a();
    rst = 1'b1;
    step_a(); idle_a();
    peek_a(0, 5'd5, "rst_r5_p0", 32'h0, 1'b0);
    peek_a(1, 5'd5, "rst_r5_p1", 32'h0, 1'b0);
    step_a();

    // Dual-write collision: port 1 wins; writes to r0 are dropped
    a_wen0 = 1'b1; a_wsel0 = 5'd7; a_wdat0 = 32'h11;
    a_wen1 = 1'b1; a_wsel1 = 5'd7; a_wdat1 = 32'h22;
    step_a(); idle_a();
    a_wen0 = 1'b1; a_wsel0 = 5'd0; a_wdat0 = 32'h55;
    step_a(); idle_a();
    peek_a(0, 5'd7, "coll_r7", 32'h22, 1'b0);
    peek_a(1, 5'd0, "r0_zero", 32'h0, 1'b0);
    step_a();

    // Scoreboard: issue sets, writeback clears, issue beats same-cycle clear
    a_iss = 1'b1; a_isel = 5'd3;
    step_a(); idle_a();
    peek_a(0, 5'd3, "sb_set_r3", 32'h0, 1'b1);
    a_wen0 = 1'b1; a_wsel0 = 5'd3; a_wdat0 = 32'h33;
    step_a(); idle_a();
    peek_a(0, 5'd3, "sb_clr_r3", 32'h33, 1'b0);
    a_wen0 = 1'b1; a_wsel0 = 5'd3; a_wdat0 = 32'h44;
    a_iss = 1'b1; a_isel = 5'd3;
    step_a(); idle_a();
    peek_a(0, 5'd3, "sb_iss_wr_r3", 32'h44, 1'b1);
    step_a();

    // Flush overrides a same-cycle issue
    a_iss = 1'b1; a_isel = 5'd4;  step_a();
    a_isel = 5'd9;                step_a();
    a_isel = 5'd12;               step_a();
    a_flush = 1'b1; a_isel = 5'd6;
    step_a(); idle_a();
    peek_a(0, 5'd4, "flush_r4", 32'h0, 1'b0);
    peek_a(1, 5'd9, "flush_r9", 32'h0, 1'b0);
    step_a();
    peek_a(0, 5'd12, "flush_r12", 32'h0, 1'b0);
    peek_a(1, 5'd6, "flush_r6", 32'h0, 1'b0);
    step_a();

    // Same-cycle read of a register being written and re-issued
    a_wen0 = 1'b1; a_wsel0 = 5'd10; a_wdat0 = 32'h1234;
    step_a(); idle_a();
    a_iss = 1'b1; a_isel = 5'd10;
    step_a(); idle_a();
    a_wen1 = 1'b1; a_wsel1 = 5'd10; a_wdat1 = 32'hA5A5;
    a_iss = 1'b1; a_isel = 5'd10;
`ifdef REGFILE_BYPASS_EN
    peek_a(0, 5'd10, "byp_r10", 32'hA5A5, 1'b0);
`else
    peek_a(0, 5'd10, "nobyp_r10", 32'h1234, 1'b1);
`endif
    step_a(); idle_a();
    peek_a(0, 5'd10, "after_wr_r10", 32'hA5A5, 1'b1);
    step_a();

    // Randomized traffic on instance A
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      a_wen0  = 1'($urandom_range(0, 1));
      a_wsel0 = pick_a();
      a_wdat0 = $urandom;
      a_wen1  = 1'($urandom_range(0, 1));
      a_wsel1 = ($urandom_range(0, 4) == 0) ? a_wsel0 : pick_a();
      a_wdat1 = $urandom;
      a_iss   = ($urandom_range(0, 2) == 0);
      a_isel  = ($urandom_range(0, 4) == 0) ? a_wsel0 : pick_a();
      a_flush = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 3))
          0:       a_rsel[i] = a_wsel0;
          1:       a_rsel[i] = a_wsel1;
          2:       a_rsel[i] = a_isel;
          default: a_rsel[i] = pick_a();
        endcase
      end
      step_a();
    end
    idle_a();
    rst = 1'b1;
    step_a();
    idle_a();

    // Instance B: fill r1..r7 while issuing each, then issue r0
    for (int r = 1; r < 8; r++) begin
      b_wen0 = 1'b1; b_wsel0 = 3'(r); b_wdat0 = 16'(16'h1000 + r * 16'h0111);
      b_iss  = 1'b1; b_isel  = 3'(r);
      step_b();
    end
    idle_b();
    b_iss = 1'b1; b_isel = 3'd0;
    step_b(); idle_b();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) b_rsel[i] = 3'((g * 4 + i + 1) % 8);
      #1;
      for (int i = 0; i < 4; i++) begin
        int r;
        r = (g * 4 + i + 1) % 8;
        chk($sformatf("sweep_r%0d_dat", r), {16'b0, b_rdat[i]},
            (r == 0) ? 32'h0 : 32'(16'h1000 + r * 16'h0111));
        chk($sformatf("sweep_r%0d_busy", r), {31'b0, b_rbusy[i]}, {31'b0, (r != 0)});
      end
      step_b();
    end

    // Randomized traffic on instance B
    for (int n = 0; n < 300; n++) begin
      rst     = ($urandom_range(0, 59) == 0);
      b_wen0  = 1'($urandom_range(0, 1));
      b_wsel0 = 3'($urandom_range(0, 7));
      b_wdat0 = 16'($urandom);
      b_wen1  = 1'($urandom_range(0, 1));
      b_wsel1 = 3'($urandom_range(0, 7));
      b_wdat1 = 16'($urandom);
      b_iss   = ($urandom_range(0, 2) == 0);
      b_isel  = 3'($urandom_range(0, 7));
      b_flush = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < 4; i++) b_rsel[i] = 3'($urandom_range(0, 7));
      step_b();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
